// File: rtl/vid_fetch_arb_if.sv
// Bus bundle between the video fetch arbiter and its surroundings.
//   host_*  : host access port (req/we/addr/wdata in, ack/rdata/rvalid out)
//   mem_*   : single-ported memory, one request per cycle, fixed read latency
//   lb_*    : line-buffer write port
// master = arbiter side, slave = host/memory/line-buffer side.
interface vid_fetch_arb_if #(
    parameter int AW = 20,
    parameter int DW = 16
);
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          lb_we;
    logic [7:0]    lb_addr;
    logic [DW-1:0] lb_data;

    modport master (
        input  host_req, host_we, host_addr, host_wdata, mem_rdata,
        output host_ack, host_rdata, host_rvalid,
               mem_req, mem_we, mem_addr, mem_wdata,
               lb_we, lb_addr, lb_data
    );

    modport slave (
        output host_req, host_we, host_addr, host_wdata, mem_rdata,
        input  host_ack, host_rdata, host_rvalid,
               mem_req, mem_we, mem_addr, mem_wdata,
               lb_we, lb_addr, lb_data
    );
endinterface

// File: rtl/vid_fetch_arb.sv
// Video line fetch / host arbiter.
// On each visible line_start, fetches WORDS words starting at
// fb_base + next_line*STRIDE into the line buffer while sharing the memory
// port with a host that is guaranteed one grant every HOST_SLOT cycles.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   line_start       : end-of-line pulse; starts a fetch when next_vis=1
//   next_line/next_vis/fb_base : next line selection, sampled at line_start
//   underrun         : sticky, a fetch was still running at the next line_start
//   bus (master)     : host port, memory port, line-buffer write port
module vid_fetch_arb #(
    parameter int AW        = 20,
    parameter int DW        = 16,
    parameter int WORDS     = 160,
    parameter int STRIDE    = 160,
    parameter int MEM_LAT   = 2,
    parameter int HOST_SLOT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          line_start,
    input  logic [10:0]   next_line,
    input  logic          next_vis,
    input  logic [AW-1:0] fb_base,
    output logic          underrun,
    vid_fetch_arb_if.master bus
);
    localparam int             SW       = (HOST_SLOT > 1) ? $clog2(HOST_SLOT) : 1;
    localparam logic [SW-1:0]  SLOT_MAX = SW'(HOST_SLOT - 1);
    localparam logic [7:0]     LAST     = 8'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] base;
    logic [7:0]    count;
    logic [SW-1:0] slot;

    // Return tag pipeline: stage k holds the request issued k cycles ago,
    // so stage MEM_LAT lines up with mem_rdata.
    logic [MEM_LAT:1]      vld_pipe;
    logic [MEM_LAT:1]      host_pipe;
    logic [MEM_LAT:1][7:0] idx_pipe;

    logic          start;
    logic          in_fetch;
    logic          host_gnt;
    logic          vid_gnt;
    logic          vid_busy;
    logic [AW-1:0] line_off;

    assign start    = line_start & next_vis;
    assign in_fetch = (state == FETCH);
    assign line_off = AW'(next_line) * AW'(STRIDE);   // wraps modulo 2^AW

    // Host is served at once outside FETCH; inside FETCH only on its slot.
    // Arbitration uses the current state even in a line_start cycle.
    assign host_gnt = ~rst & bus.host_req & (~in_fetch | (slot == SLOT_MAX));
    assign vid_gnt  = ~rst & in_fetch & ~host_gnt;

    // A video read still in flight, excluding the one returning this cycle.
    always_comb begin
        vid_busy = 1'b0;
        for (int i = 1; i < MEM_LAT; i++)
            vid_busy = vid_busy | (vld_pipe[i] & ~host_pipe[i]);
    end

    assign bus.mem_req     = host_gnt | vid_gnt;
    assign bus.mem_we      = host_gnt & bus.host_we;
    assign bus.mem_addr    = host_gnt ? bus.host_addr : base + AW'(count);
    assign bus.mem_wdata   = bus.host_wdata;
    assign bus.host_ack    = host_gnt;

    assign bus.host_rvalid = vld_pipe[MEM_LAT] & host_pipe[MEM_LAT];
    assign bus.host_rdata  = bus.mem_rdata;
    assign bus.lb_we       = vld_pipe[MEM_LAT] & ~host_pipe[MEM_LAT];
    assign bus.lb_addr     = idx_pipe[MEM_LAT];
    assign bus.lb_data     = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            count     <= '0;
            slot      <= '0;
            underrun  <= 1'b0;
            vld_pipe  <= '0;
            host_pipe <= '0;
            idx_pipe  <= '0;
        end else begin
            // Writes need no return slot.
            vld_pipe[1]  <= bus.mem_req & ~bus.mem_we;
            host_pipe[1] <= host_gnt;
            idx_pipe[1]  <= count;
            for (int i = 2; i <= MEM_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                host_pipe[i] <= host_pipe[i-1];
                idx_pipe[i]  <= idx_pipe[i-1];
            end

            if (host_gnt || start)
                slot <= '0;
            else if (in_fetch && slot != SLOT_MAX)
                slot <= slot + 1'b1;

            if (start) begin
                // Restart even mid-fetch; in-flight returns keep draining.
                if (state != IDLE)
                    underrun <= 1'b1;
                state <= FETCH;
                base  <= fb_base + line_off;
                count <= '0;
            end else begin
                case (state)
                    FETCH: if (vid_gnt) begin
                        count <= count + 1'b1;
                        if (count == LAST)
                            state <= DRAIN;
                    end
                    DRAIN: if (!vid_busy)
                        state <= IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vid_fetch_arb.sv
module tb_vid_fetch_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [10:0] next_line;
    logic        next_vis;
    logic [19:0] fb_base;
    logic        underrun;

    vid_fetch_arb_if #(.AW(20), .DW(16)) bus ();

    vid_fetch_arb #(
        .AW(20), .DW(16), .WORDS(160), .STRIDE(160), .MEM_LAT(2), .HOST_SLOT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .next_line  (next_line),
        .next_vis   (next_vis),
        .fb_base    (fb_base),
        .underrun   (underrun),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdat(input logic [19:0] a);
        return a[15:0] ^ {12'h5A3, a[19:16]};
    endfunction

    // Memory model: read data appears two cycles after the request.
    logic        rv1, rv2;
    logic [19:0] ra1, ra2;
    always @(posedge clk) begin
        rv1 <= bus.mem_req && !bus.mem_we;
        ra1 <= bus.mem_addr;
        rv2 <= rv1;
        ra2 <= ra1;
    end
    assign bus.mem_rdata = rv2 ? mdat(ra2) : 16'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: expected return timing/data derived from observed issues.
    logic [19:0] tb_base;
    logic [1:0]  vd_h, hr_h;
    logic [19:0] va_h [2];
    logic [19:0] ha_h [2];
    logic [7:0]  vi_h [2];
    int lat_err = 0, data_err = 0;
    int n_vrd, n_lbwe, n_hack, n_hrv, n_hack_f;
    int first_cyc, last_cyc, first_lb_cyc, first_hack_cyc;
    logic [19:0] first_addr, last_addr;
    logic vid;

    always @(negedge clk) begin
        if (rst) begin
            vd_h = '0;
            hr_h = '0;
        end else begin
            if (bus.lb_we !== vd_h[1]) lat_err++;
            if (bus.lb_we && (bus.lb_addr !== vi_h[1] || bus.lb_data !== mdat(va_h[1]))) data_err++;
            if (bus.host_rvalid !== hr_h[1]) lat_err++;
            if (bus.host_rvalid && bus.host_rdata !== mdat(ha_h[1])) data_err++;

            vid = bus.mem_req && !bus.host_ack;
            if (vid) begin
                if (n_vrd == 0) begin first_cyc = cyc; first_addr = bus.mem_addr; end
                last_cyc  = cyc;
                last_addr = bus.mem_addr;
                n_vrd++;
            end
            if (bus.lb_we) begin
                if (n_lbwe == 0) first_lb_cyc = cyc;
                n_lbwe++;
            end
            if (bus.host_ack) begin
                if (first_hack_cyc < 0) first_hack_cyc = cyc;
                if (n_vrd > 0 && n_vrd < 160) n_hack_f++;
                n_hack++;
            end
            if (bus.host_rvalid) n_hrv++;

            vd_h    = {vd_h[0], vid};
            va_h[1] = va_h[0]; va_h[0] = bus.mem_addr;
            vi_h[1] = vi_h[0]; vi_h[0] = 8'(bus.mem_addr - tb_base);
            hr_h    = {hr_h[0], bus.host_ack && !bus.mem_we};
            ha_h[1] = ha_h[0]; ha_h[0] = bus.mem_addr;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_stats();
        n_vrd = 0; n_lbwe = 0; n_hack = 0; n_hrv = 0; n_hack_f = 0;
        first_hack_cyc = -1;
    endtask

    task automatic pulse_line(input logic [19:0] b, input logic [10:0] l, input logic v);
        fb_base = b; next_line = l; next_vis = v; line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_lb(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && n_lbwe < n; i++) tick();
        chk(tag, n_lbwe, n);
    endtask

    initial begin
        rst = 1'b1; line_start = 1'b0; next_line = '0; next_vis = 1'b0; fb_base = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        tb_base = '0;
        clear_stats();

        // Reset state
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_lb_we", bus.lb_we, 0);
        chk("rst_hrvalid", bus.host_rvalid, 0);
        chk("rst_underrun", underrun, 0);
        tick();

        // Invisible line: no fetch
        clear_stats();
        pulse_line(20'h0, 11'd7, 1'b0);
        repeat (5) tick();
        chk("novis_reads", n_vrd, 0);

        // Plain line fetch, line 5 -> 800..959
        clear_stats();
        tb_base = 20'd800;
        pulse_line(20'h0, 11'd5, 1'b1);
        wait_lb("l5_lb_cnt", 160, 400);
        chk("l5_reads", n_vrd, 160);
        chk("l5_first", first_addr, 800);
        chk("l5_last", last_addr, 959);
        chk("l5_lat", first_lb_cyc - first_cyc, 2);
        chk("l5_underrun", underrun, 0);

        // Host read in idle: ack same cycle, rvalid two cycles later
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 20'h12345;
        @(negedge clk);
        chk("hrd_ack", bus.host_ack, 1);
        chk("hrd_addr", bus.mem_addr, 20'h12345);
        tick(); bus.host_req = 1'b0;
        @(negedge clk);
        chk("hrd_rv_early", bus.host_rvalid, 0);
        tick();
        @(negedge clk);
        chk("hrd_rv", bus.host_rvalid, 1);
        chk("hrd_data", bus.host_rdata, mdat(20'h12345));
        tick();

        // Host write in idle
        clear_stats();
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 20'hABCDE; bus.host_wdata = 16'hBEEF;
        @(negedge clk);
        chk("hwr_ack", bus.host_ack, 1);
        chk("hwr_we", bus.mem_we, 1);
        chk("hwr_addr", bus.mem_addr, 20'hABCDE);
        chk("hwr_data", bus.mem_wdata, 16'hBEEF);
        tick();
        bus.host_req = 1'b0; bus.host_we = 1'b0;
        repeat (4) tick();
        chk("hwr_norv", n_hrv, 0);

        // Fetch with host held: 0x3000 + 10*160 = 0x3640
        clear_stats();
        tb_base = 20'h03640;
        pulse_line(20'h03000, 11'd10, 1'b1);
        bus.host_req = 1'b1; bus.host_addr = 20'h00777;
        for (int i = 0; i < 400 && n_vrd < 160; i++) tick();
        bus.host_req = 1'b0;
        chk("hh_first", first_addr, 20'h03640);
        chk("hh_span", last_cyc - first_cyc + 1, 213);
        chk("hh_slot", first_hack_cyc - first_cyc, 3);
        chk("hh_hgrants", n_hack_f, 53);
        wait_lb("hh_lb_cnt", 160, 50);
        repeat (4) tick();
        chk("hh_rvalids", n_hrv, n_hack);

        // Underrun: restart after 100 cycles of fetch
        clear_stats();
        tb_base = 20'h01000;
        pulse_line(20'h01000, 11'd0, 1'b1);
        repeat (99) tick();
        fb_base = 20'h02000; next_line = 11'd2; next_vis = 1'b1; line_start = 1'b1;
        @(negedge clk); #1;
        clear_stats();
        tb_base = 20'h02140;
        tick();
        line_start = 1'b0;
        @(negedge clk);
        chk("ur_flag", underrun, 1);
        chk("ur_new_addr", bus.mem_addr, 20'h02140);
        chk("ur_inflight_we", bus.lb_we, 1);
        chk("ur_inflight_idx", bus.lb_addr, 98);
        wait_lb("ur_lb_cnt", 162, 400);
        chk("ur_reads", n_vrd, 160);
        repeat (4) tick();

        // Reset mid-fetch
        tb_base = 20'd160;
        pulse_line(20'h0, 11'd1, 1'b1);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_stats();
        @(negedge clk);
        chk("mrst_mem_req", bus.mem_req, 0);
        chk("mrst_host_ack", bus.host_ack, 0);
        chk("mrst_lb_we", bus.lb_we, 0);
        chk("mrst_hrvalid", bus.host_rvalid, 0);
        chk("mrst_underrun", underrun, 0);
        repeat (10) tick();
        chk("mrst_no_lb", n_lbwe, 0);
        chk("mrst_no_rd", n_vrd, 0);

        // Wrap: 0xFFF00 + 1023*160 mod 2^20 = 0x27E60
        clear_stats();
        tb_base = 20'h27E60;
        pulse_line(20'hFFF00, 11'd1023, 1'b1);
        wait_lb("wr_lb_cnt", 160, 400);
        chk("wr_first", first_addr, 20'h27E60);
        chk("wr_last", last_addr, 20'h27EFF);

        chk("lat_errors", lat_err, 0);
        chk("data_errors", data_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vid_fetch_arb.md
VID_FETCH_ARB -- requirements
Module: vid_fetch_arb

Interface
REQ-001 Parameter AW, default 20: memory word-address width.
REQ-002 Parameter DW, default 16: memory data width.
REQ-003 Parameter WORDS, default 160: words fetched per visible line (1280 px at 8 px/word).
REQ-004 Parameter STRIDE, default 160: word distance between consecutive lines in memory.
REQ-005 Parameter MEM_LAT, default 2: fixed read latency in cycles, from accepted request to mem_rdata valid.
REQ-006 Parameter HOST_SLOT, default 4: the host is guaranteed one grant in every HOST_SLOT cycles during a fetch.
REQ-007 clk  in  1  pixel clock, single clock domain.
REQ-008 rst  in  1  reset; synchronous, active-high.
REQ-009 line_start  in  1  one-cycle pulse at the end of each line (timing generator eol).
REQ-010 next_line  in  11  index of the next line to display (0..1023).
REQ-011 next_vis  in  1  next line is visible; a fetch is needed.
REQ-012 fb_base  in  AW  frame-buffer base word address; sampled at line_start.
REQ-013 host_req  in  1  host access request; held until host_ack.
REQ-014 host_we  in  1  host write (1) or read (0).
REQ-015 host_addr  in  AW  host word address.
REQ-016 host_wdata  in  DW  host write data.
REQ-017 host_ack  out  1  one-cycle pulse when the host request is issued to memory.
REQ-018 host_rdata  out  DW  host read data.
REQ-019 host_rvalid  out  1  one-cycle pulse; host_rdata is valid.
REQ-020 mem_req  out  1  memory request this cycle; always accepted.
REQ-021 mem_we  out  1  memory write enable.
REQ-022 mem_addr  out  AW  memory word address.
REQ-023 mem_wdata  out  DW  memory write data.
REQ-024 mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the read request.
REQ-025 lb_we  out  1  line-buffer write strobe.
REQ-026 lb_addr  out  8  line-buffer word index, 0..WORDS-1.
REQ-027 lb_data  out  DW  line-buffer write data.
REQ-028 underrun  out  1  sticky flag: a fetch did not complete before the next line_start.

Function
REQ-029 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
REQ-030 IDLE->FETCH SHALL occur on line_start && next_vis; the block SHALL then latch base = fb_base + next_line*STRIDE (AW-bit, wrap modulo 2^AW) and clear the word count.
REQ-031 In FETCH, each video grant SHALL issue a read at base+count and increment count; after grant WORDS-1 the FSM SHALL move to DRAIN.
REQ-032 DRAIN->IDLE SHALL occur once no video reads are outstanding (MEM_LAT cycles after the last issue).
REQ-033 Arbitration in FETCH: video SHALL win by default; the host SHALL win when host_req=1 and the slot counter equals HOST_SLOT-1.
REQ-034 The slot counter SHALL reset to 0 on any host grant and on entry to FETCH; it SHALL saturate at HOST_SLOT-1.
REQ-035 In IDLE and DRAIN, host_req SHALL be granted in the same cycle it is seen.
REQ-036 At most one mem_req SHALL issue per cycle; host_ack SHALL equal the host grant in that cycle.
REQ-037 Read returns SHALL be routed by a MEM_LAT-deep tag pipeline (video/host, line-buffer index).
REQ-038 On a video return, lb_we=1 and lb_addr = the issued index; on a host return, host_rvalid=1; host writes SHALL produce no return.
REQ-039 line_start with next_vis while in FETCH or DRAIN SHALL set underrun, abort the current fetch and restart FETCH at the new base; read returns already in the pipeline SHALL still be written to the line buffer.
REQ-040 line_start with next_vis=0 SHALL leave the state unchanged.
REQ-041 A host request seen in the same cycle as line_start SHALL be arbitrated as in the current (pre-transition) state.

Reset
REQ-042 On rst: FSM=IDLE, count=0, slot counter=0, tag pipeline cleared, underrun=0.
REQ-043 On rst: mem_req, host_ack, host_rvalid and lb_we SHALL be 0 in the following cycle.
REQ-044 rst mid-fetch SHALL discard all outstanding returns.

Verification
REQ-045 Idle line: fb_base=0, next_line=5, no host -> 160 reads at addresses 800..959; lb_we at indices 0..159, each MEM_LAT cycles after issue; DRAIN->IDLE.
REQ-046 Fetch with host_req held continuously -> host granted every 4th cycle; the video fetch finishes in 213 cycles; host reads return with host_rvalid after 2 cycles.
REQ-047 Back-to-back line_start after 100 cycles of fetch -> underrun=1; the new fetch starts at the new base; in-flight data is written to the line buffer.
REQ-048 Host write in IDLE -> host_ack in the same cycle; mem_we=1; no host_rvalid.
REQ-049 Reset asserted mid-fetch -> all strobes 0 in the next cycle; no lb_we afterward.
REQ-050 next_line=1023, fb_base near 2^20 -> base wraps modulo 2^20.
